gp_width_pack: RTL and testbench
================================

Name: gp_width_pack

Overview:
- Downstream stage of the synchronous FIFO.
- Consumes narrow DATA_WIDTH beats from the FIFO read channel over valid/ready and packs RATIO consecutive beats into one wide output word.
- An early packet end (s_last_i) flushes a partial word, with a per-lane keep mask.
- Typical use: FIFO-buffered narrow stream feeding a wide datapath or memory write port.

Parameters:
- DATA_WIDTH, 32, width of one input beat (one lane).
- RATIO, 4, input beats per output word; legal range RATIO >= 2.

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  reset; asynchronous assert, active-low.
- s_ready_o  output  1  input channel ready.
- s_valid_i  input  1  input beat valid.
- s_data_i  input  DATA_WIDTH  input beat data.
- s_last_i  input  1  beat is last of packet; forces flush.
- m_ready_i  input  1  output channel ready.
- m_valid_o  output  1  packed word valid.
- m_data_o  output  RATIO*DATA_WIDTH  packed word; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- m_keep_o  output  RATIO  lane i holds valid data.
- m_last_o  output  1  word ends a packet.

Interface (already decided):
- One clock; reset is asynchronous and active-low. Clock clk_i, reset rst_n_i.

Behaviour:
- Handshakes:
  - Input accepted (in_hs) when s_valid_i & s_ready_o.
  - Output accepted (out_hs) when m_valid_o & m_ready_i.
  - Standard valid/ready rules: m_valid_o, once high, holds until out_hs, and m_data_o, m_keep_o and m_last_o stay stable while held.
- s_ready_o = ~m_valid_o | m_ready_i.
  - Combinational path m_ready_i -> s_ready_o is intentional.
  - s_ready_o does not depend on s_valid_i, s_data_i or s_last_i.
- Internal state:
  - lane counter cnt, width $clog2(RATIO), range 0..RATIO-1.
  - accumulator acc_data of RATIO-1 lanes, plus acc_keep.
  - output register (m_data_o, m_keep_o, m_last_o, m_valid_o).
- Lane order: the first beat of a word goes to lane 0 (LSBs); beat k goes to lane k.
- Non-completing beat: an in_hs with cnt < RATIO-1 and s_last_i=0.
  - Store the beat in acc lane cnt.
  - Set acc_keep[cnt]; cnt <= cnt+1.
- Completing beat: an in_hs with cnt == RATIO-1, or s_last_i=1 at any cnt.
  - Output register <= acc lanes 0..cnt-1, plus the new beat in lane cnt.
  - Lanes above cnt are zero.
  - m_keep_o = ones in bits 0..cnt, zeros above.
  - m_last_o = s_last_i.
  - m_valid_o <= 1; cnt <= 0; acc_keep <= 0.
- Latency: a completing beat accepted in cycle N gives m_valid_o=1 in cycle N+1.
- Throughput: with m_ready_i held at 1, one beat is accepted every cycle, with no bubbles.
- m_valid_o next-state:
  - set by a completing beat;
  - else cleared by out_hs;
  - else held.
  - If out_hs and a completing beat occur in the same cycle, the output register is reloaded and m_valid_o stays 1.
- Word boundary by count: a full word of RATIO beats with s_last_i=0 on the final beat gives m_last_o=0 and m_keep_o all ones.
- Single-beat packet: s_last_i=1 at cnt=0 gives m_keep_o=1 (lane 0 only).
- Counter wrap: cnt never exceeds RATIO-1 and returns to 0 after every completing beat.
- Reset, asynchronous at any time (including mid-word and while an output is pending):
  - cnt=0, acc cleared, m_valid_o=0, m_data_o=0, m_keep_o=0, m_last_o=0.
  - s_ready_o=1 follows from m_valid_o=0.
  - A partially accumulated word is discarded; nothing is emitted for it.
- Held input: s_valid_i held low leaves the state unchanged indefinitely; there is no timeout flush.

Decomposition:
- No shared package entry required.
- LANE_CNT_W = $clog2(RATIO) and OUT_WIDTH = RATIO*DATA_WIDTH are local parameters.
- Single flat module, no sub-module.
- The upstream gp_fifo_sync is instantiated by the integrating level, not inside this block.

Test Plan (DATA_WIDTH=8, RATIO=4):
1. Beats 0x11, 0x22, 0x33, 0x44, last=0 on all, m_ready_i=1 -> one cycle after the 4th beat: m_data_o=0x44332211, m_keep_o=0xF, m_last_o=0, m_valid_o high for 1 cycle.
2. Beats 0xAA, 0xBB with last=1 on 0xBB -> m_data_o=0x0000BBAA, m_keep_o=0x3, m_last_o=1. Then a single beat 0xCC with last=1 -> m_data_o=0x000000CC, m_keep_o=0x1, m_last_o=1.
3. Eight back-to-back beats 0x01..0x08, m_ready_i=1 -> s_ready_o stays 1 throughout; words 0x04030201 then 0x08070605 appear 4 cycles apart.
4. Complete a word while m_ready_i=0 -> m_valid_o=1 and s_ready_o=0, data stable for 5 cycles. Raise m_ready_i in a cycle that also presents the next completing beat -> same-cycle reload, m_valid_o remains 1 with the new word.
5. Accept beats 0x11, 0x22, assert rst_n_i=0 mid-cycle -> outputs clear immediately, without waiting for a clock edge. After release, beats 0x55..0x58 -> m_data_o=0x58575655 with no trace of 0x11 or 0x22.
6. Reset while m_valid_o=1 and m_ready_i=0 -> m_valid_o=0 and s_ready_o=1 immediately; the pending word is never delivered.

Source files
------------

// File: rtl/gp_width_pack_pkg.sv
// Shared helpers for the narrow-to-wide beat packer.
package gp_width_pack_pkg;

    // Lane counter width; kept at least 1 bit so a counter can always be declared.
    function automatic int lane_cnt_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/gp_width_pack.sv
// Packs RATIO consecutive DATA_WIDTH beats into one wide word; s_last_i flushes
// a partial word early with a per-lane keep mask.
module gp_width_pack
    import gp_width_pack_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RATIO      = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    output logic                        s_ready_o,
    input  logic                        s_valid_i,
    input  logic [DATA_WIDTH-1:0]       s_data_i,
    input  logic                        s_last_i,
    input  logic                        m_ready_i,
    output logic                        m_valid_o,
    output logic [RATIO*DATA_WIDTH-1:0] m_data_o,
    output logic [RATIO-1:0]            m_keep_o,
    output logic                        m_last_o
);

    localparam int LANE_CNT_W = lane_cnt_w(RATIO);
    localparam int OUT_WIDTH  = RATIO * DATA_WIDTH;
    localparam int ACC_WIDTH  = (RATIO - 1) * DATA_WIDTH;

    logic [LANE_CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]  acc_data_q, acc_data_d;
    logic [RATIO-2:0]      acc_keep_q, acc_keep_d;
    logic                  m_valid_q, m_valid_d;
    logic [OUT_WIDTH-1:0]  m_data_q, m_data_d;
    logic [RATIO-1:0]      m_keep_q, m_keep_d;
    logic                  m_last_q, m_last_d;

    logic                  in_hs;
    logic                  out_hs;
    logic                  completing;
    logic [OUT_WIDTH-1:0]  acc_ext;

    assign s_ready_o  = ~m_valid_q | m_ready_i;
    assign in_hs      = s_valid_i & s_ready_o;
    assign out_hs     = m_valid_q & m_ready_i;
    assign completing = in_hs & ((cnt_q == LANE_CNT_W'(RATIO - 1)) | s_last_i);
    // Padding the top lane lets the output loop index every lane uniformly.
    assign acc_ext    = {{DATA_WIDTH{1'b0}}, acc_data_q};

    always_comb begin
        cnt_d      = cnt_q;
        acc_data_d = acc_data_q;
        acc_keep_d = acc_keep_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_keep_d   = m_keep_q;
        m_last_d   = m_last_q;

        if (completing) begin
            for (int i = 0; i < RATIO; i++) begin
                if (LANE_CNT_W'(i) == cnt_q) begin
                    m_data_d[i*DATA_WIDTH +: DATA_WIDTH] = s_data_i;
                    m_keep_d[i]                          = 1'b1;
                end else if (LANE_CNT_W'(i) < cnt_q) begin
                    m_data_d[i*DATA_WIDTH +: DATA_WIDTH] = acc_ext[i*DATA_WIDTH +: DATA_WIDTH];
                    m_keep_d[i]                          = 1'b1;
                end else begin
                    m_data_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                    m_keep_d[i]                          = 1'b0;
                end
            end
            m_last_d   = s_last_i;
            m_valid_d  = 1'b1;
            cnt_d      = '0;
            acc_keep_d = '0;
        end else begin
            if (in_hs) begin
                for (int i = 0; i < RATIO - 1; i++) begin
                    if (LANE_CNT_W'(i) == cnt_q) begin
                        acc_data_d[i*DATA_WIDTH +: DATA_WIDTH] = s_data_i;
                        acc_keep_d[i]                          = 1'b1;
                    end
                end
                cnt_d = cnt_q + LANE_CNT_W'(1);
            end
            if (out_hs) begin
                m_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q      <= '0;
            acc_data_q <= '0;
            acc_keep_q <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_last_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_data_q <= acc_data_d;
            acc_keep_q <= acc_keep_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_keep_q   <= m_keep_d;
            m_last_q   <= m_last_d;
        end
    end

    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;
    assign m_keep_o  = m_keep_q;
    assign m_last_o  = m_last_q;

endmodule

// File: tb/tb_gp_width_pack.sv
// Bench for gp_width_pack: directed scenarios plus random traffic against a
// queue-based packet model.
module tb_gp_width_pack;

    localparam int DW    = 8;
    localparam int RATIO = 4;
    localparam int OW    = DW * RATIO;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          s_ready_o;
    logic          s_valid_i;
    logic [DW-1:0] s_data_i;
    logic          s_last_i;
    logic          m_ready_i;
    logic          m_valid_o;
    logic [OW-1:0] m_data_o;
    logic [RATIO-1:0] m_keep_o;
    logic          m_last_o;

    gp_width_pack #(.DATA_WIDTH(DW), .RATIO(RATIO)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .s_ready_o (s_ready_o),
        .s_valid_i (s_valid_i),
        .s_data_i  (s_data_i),
        .s_last_i  (s_last_i),
        .m_ready_i (m_ready_i),
        .m_valid_o (m_valid_o),
        .m_data_o  (m_data_o),
        .m_keep_o  (m_keep_o),
        .m_last_o  (m_last_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [OW-1:0]    data;
        logic [RATIO-1:0] keep;
        logic             last;
    } word_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] cur_q[$];
    word_t         exp_q[$];
    logic          hold_prev = 1'b0;
    logic [OW-1:0] data_prev;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: collect beats of the current word; a word ends on last or when full.
    task automatic model_beat(input logic [DW-1:0] d, input logic l);
        word_t w;
        cur_q.push_back(d);
        if (l || cur_q.size() == RATIO) begin
            w.data = '0;
            foreach (cur_q[k]) w.data = w.data | (OW'(cur_q[k]) << (DW * k));
            w.keep = RATIO'((1 << cur_q.size()) - 1);
            w.last = l;
            exp_q.push_back(w);
            cur_q.delete();
        end
    endtask

    // One clock: observe at the falling edge, then advance past the rising edge.
    task automatic tick();
        word_t e;
        @(negedge clk_i);
        check_eq("s_ready_rule", s_ready_o, !m_valid_o || m_ready_i);
        if (hold_prev) begin
            check_eq("hold_valid", m_valid_o, 1'b1);
            check_eq("hold_data", m_data_o, data_prev);
        end
        if (m_valid_o && m_ready_i) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_word", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check_eq("word_data", m_data_o, e.data);
                check_eq("word_keep", m_keep_o, e.keep);
                check_eq("word_last", m_last_o, e.last);
            end
        end
        hold_prev = m_valid_o && !m_ready_i;
        data_prev = m_data_o;
        if (s_valid_i && s_ready_o) model_beat(s_data_i, s_last_i);
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = l;
        tick();
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic reset_now();
        rst_n_i = 1'b0;
        #1;
        cur_q.delete();
        exp_q.delete();
        hold_prev = 1'b0;
        check_eq("rst_valid", m_valid_o, 1'b0);
        check_eq("rst_data", m_data_o, '0);
        check_eq("rst_keep", m_keep_o, '0);
        check_eq("rst_last", m_last_o, 1'b0);
        check_eq("rst_ready", s_ready_o, 1'b1);
        #1;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_n_i   = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        s_last_i  = 1'b0;
        m_ready_i = 1'b1;
        #12;
        check_eq("reset_valid", m_valid_o, 1'b0);
        check_eq("reset_ready", s_ready_o, 1'b1);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Full word by count
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        check_eq("t1_valid", m_valid_o, 1'b1);
        check_eq("t1_data", m_data_o, 32'h4433_2211);
        check_eq("t1_keep", m_keep_o, 4'hF);
        check_eq("t1_last", m_last_o, 1'b0);
        tick();
        check_eq("t1_one_cycle", m_valid_o, 1'b0);

        // Early flush and single-beat packet
        send(8'hAA, 0); send(8'hBB, 1);
        check_eq("t2_data", m_data_o, 32'h0000_BBAA);
        check_eq("t2_keep", m_keep_o, 4'h3);
        check_eq("t2_last", m_last_o, 1'b1);
        send(8'hCC, 1);
        check_eq("t2b_data", m_data_o, 32'h0000_00CC);
        check_eq("t2b_keep", m_keep_o, 4'h1);
        tick();

        // Back-to-back, no bubbles
        for (int i = 1; i <= 8; i++) begin
            check_eq("t3_ready", s_ready_o, 1'b1);
            send(DW'(i), 0);
            if (i == 4) check_eq("t3_word0", m_data_o, 32'h0403_0201);
        end
        check_eq("t3_word1", m_data_o, 32'h0807_0605);
        tick();

        // Backpressure, then same-cycle reload
        m_ready_i = 1'b0;
        send(8'h61, 0); send(8'h62, 0); send(8'h63, 0); send(8'h64, 0);
        for (int i = 0; i < 5; i++) begin
            check_eq("t4_stall_ready", s_ready_o, 1'b0);
            tick();
        end
        check_eq("t4_held_data", m_data_o, 32'h6463_6261);
        m_ready_i = 1'b1;
        send(8'h7E, 1);
        check_eq("t4_reload_valid", m_valid_o, 1'b1);
        check_eq("t4_reload_data", m_data_o, 32'h0000_007E);
        tick();

        // Reset mid-word discards partial data
        send(8'h11, 0); send(8'h22, 0);
        #2;
        reset_now();
        send(8'h55, 0); send(8'h56, 0); send(8'h57, 0); send(8'h58, 0);
        check_eq("t5_data", m_data_o, 32'h5857_5655);
        tick();

        // Reset with a pending word
        m_ready_i = 1'b0;
        send(8'h91, 1);
        check_eq("t6_pending", m_valid_o, 1'b1);
        #2;
        reset_now();
        m_ready_i = 1'b1;
        tick();
        check_eq("t6_not_delivered", m_valid_o, 1'b0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            s_valid_i = ($urandom_range(0, 9) < 7);
            s_data_i  = DW'($urandom_range(0, 255));
            s_last_i  = ($urandom_range(0, 99) < 15);
            m_ready_i = ($urandom_range(0, 9) < 6);
            tick();
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        m_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
        check_eq("drain_valid", m_valid_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
